// File: rtl/write_combine_buffer_if.sv
// Bus bundle for the write-combine buffer: CPU write/read port, memory write port and status.
interface write_combine_buffer_if #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned LINE_BYTES = 32,
    parameter int unsigned ADDR_W     = 32
);
    localparam int unsigned DATA_W = 8 * LINE_BYTES;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    logic                  cpu_wvalid;
    logic                  cpu_wready;
    logic [ADDR_W-1:0]     cpu_waddr;
    logic [DATA_W-1:0]     cpu_wdata;
    logic [LINE_BYTES-1:0] cpu_wstrb;
    logic [ADDR_W-1:0]     cpu_raddr;
    logic                  cpu_rhit;
    logic [DATA_W-1:0]     cpu_rdata;
    logic [LINE_BYTES-1:0] cpu_rmask;
    logic                  mem_wvalid;
    logic                  mem_wready;
    logic [ADDR_W-1:0]     mem_waddr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [LINE_BYTES-1:0] mem_wstrb;
    logic                  mem_bvalid;
    logic                  empty;
    logic                  full;
    logic [CNT_W-1:0]      count;

    modport master (
        output cpu_wvalid, cpu_waddr, cpu_wdata, cpu_wstrb, cpu_raddr, mem_wready, mem_bvalid,
        input  cpu_wready, cpu_rhit, cpu_rdata, cpu_rmask,
        input  mem_wvalid, mem_waddr, mem_wdata, mem_wstrb, empty, full, count
    );

    modport slave (
        input  cpu_wvalid, cpu_waddr, cpu_wdata, cpu_wstrb, cpu_raddr, mem_wready, mem_bvalid,
        output cpu_wready, cpu_rhit, cpu_rdata, cpu_rmask,
        output mem_wvalid, mem_waddr, mem_wdata, mem_wstrb, empty, full, count
    );
endinterface

// File: rtl/write_combine_buffer.sv
// Line-granular write-combining FIFO: merges CPU writes into unlocked entries, drains the
// head to memory one line at a time, and forwards buffered bytes to same-cycle reads.
module write_combine_buffer #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned LINE_BYTES = 32,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    write_combine_buffer_if.slave bus
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
    localparam int unsigned LINE_W = ADDR_W - OFF_W;
    localparam int unsigned DATA_W = 8 * LINE_BYTES;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_B} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DEPTH-1:0]    valid_q, valid_d;

    logic [LINE_W-1:0]     line_q [DEPTH];
    logic [DATA_W-1:0]     data_q [DEPTH];
    logic [LINE_BYTES-1:0] mask_q [DEPTH];

    logic [LINE_W-1:0]     wline_c, rline_c;
    logic                  merge_hit_c, accept_c, alloc_c, pop_c;
    logic [PTR_W-1:0]      merge_idx_c, wr_idx_c, rd_idx_c;
    logic [DATA_W-1:0]     strb_bits_c, wr_data_c, rdata_c;
    logic [LINE_BYTES-1:0] wr_mask_c, rmask_c;
    logic                  unused_addr_bits;

    assign wline_c = bus.cpu_waddr[ADDR_W-1:OFF_W];
    assign rline_c = bus.cpu_raddr[ADDR_W-1:OFF_W];
    assign unused_addr_bits = ^{bus.cpu_waddr[OFF_W-1:0], bus.cpu_raddr[OFF_W-1:0]};

    // Merge target: valid entry of the same line, excluding the head while it is draining
    always_comb begin
        merge_hit_c = 1'b0;
        merge_idx_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (line_q[i] == wline_c) &&
                !((state_q != IDLE) && (PTR_W'(i) == head_q))) begin
                merge_hit_c = 1'b1;
                merge_idx_c = PTR_W'(i);
            end
        end
    end

    assign bus.cpu_wready = (count_q < CNT_W'(DEPTH)) || merge_hit_c;
    assign accept_c       = bus.cpu_wvalid && bus.cpu_wready;
    assign alloc_c        = accept_c && !merge_hit_c;
    assign pop_c          = (state_q == WAIT_B) && bus.mem_bvalid;

    always_comb begin
        strb_bits_c = '0;
        for (int b = 0; b < LINE_BYTES; b++) begin
            strb_bits_c[b*8 +: 8] = {8{bus.cpu_wstrb[b]}};
        end
        wr_idx_c  = merge_hit_c ? merge_idx_c : tail_q;
        wr_data_c = bus.cpu_wdata;
        wr_mask_c = bus.cpu_wstrb;
        if (merge_hit_c) begin
            wr_data_c = (data_q[merge_idx_c] & ~strb_bits_c) | (bus.cpu_wdata & strb_bits_c);
            wr_mask_c = mask_q[merge_idx_c] | bus.cpu_wstrb;
        end
    end

    // Entry payload storage carries no reset; valid bits qualify every use
    always_ff @(posedge clk) begin
        if (accept_c) begin
            line_q[wr_idx_c] <= wline_c;
            data_q[wr_idx_c] <= wr_data_c;
            mask_q[wr_idx_c] <= wr_mask_c;
        end
    end

    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (alloc_c) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        if (pop_c) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(alloc_c) - CNT_W'(pop_c);
    end

    // Drain FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid_q[head_q])   state_d = SEND;
            SEND:    if (bus.mem_wready)    state_d = WAIT_B;
            WAIT_B:  if (bus.mem_bvalid)    state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Read forwarding: walk oldest to youngest so younger entries override per byte
    always_comb begin
        rdata_c  = '0;
        rmask_c  = '0;
        rd_idx_c = '0;
        for (int k = 0; k < DEPTH; k++) begin
            rd_idx_c = head_q + PTR_W'(k);
            if (valid_q[rd_idx_c] && (line_q[rd_idx_c] == rline_c)) begin
                rmask_c = rmask_c | mask_q[rd_idx_c];
                for (int b = 0; b < LINE_BYTES; b++) begin
                    if (mask_q[rd_idx_c][b]) begin
                        rdata_c[b*8 +: 8] = data_q[rd_idx_c][b*8 +: 8];
                    end
                end
            end
        end
    end

    assign bus.cpu_rdata  = rdata_c;
    assign bus.cpu_rmask  = rmask_c;
    assign bus.cpu_rhit   = |rmask_c;

    assign bus.mem_wvalid = (state_q == SEND);
    assign bus.mem_waddr  = {line_q[head_q], OFF_W'(0)};
    assign bus.mem_wdata  = data_q[head_q];
    assign bus.mem_wstrb  = mask_q[head_q];

    assign bus.count      = count_q;
    assign bus.empty      = (count_q == '0);
    assign bus.full       = (count_q == CNT_W'(DEPTH));
endmodule

// File: doc/write_combine_buffer.md
WRITE_COMBINE_BUFFER -- requirements
Module: write_combine_buffer

Interface
REQ-001 Parameter DEPTH, default 8: number of line entries; power of two, >= 2.
REQ-002 Parameter LINE_BYTES, default 32: bytes per cache line; power of two, >= 4.
REQ-003 Parameter ADDR_W, default 32: address width.
REQ-004 Clocking SHALL be exactly: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 cpu_wvalid  in  1  CPU write request.
REQ-008 cpu_wready  out  1  buffer accepts the write this cycle.
REQ-009 cpu_waddr  in  ADDR_W  write byte address; low log2(LINE_BYTES) bits ignored.
REQ-010 cpu_wdata  in  8*LINE_BYTES  write line data.
REQ-011 cpu_wstrb  in  LINE_BYTES  per-byte write enables.
REQ-012 cpu_raddr  in  ADDR_W  read lookup address; low bits ignored.
REQ-013 cpu_rhit  out  1  some buffered byte of the line is valid.
REQ-014 cpu_rdata  out  8*LINE_BYTES  forwarded bytes; 0 where not valid.
REQ-015 cpu_rmask  out  LINE_BYTES  which bytes of cpu_rdata are valid.
REQ-016 mem_wvalid / mem_wready  out / in  1  memory write address+data handshake.
REQ-017 mem_waddr / mem_wdata / mem_wstrb  out  ADDR_W / 8*LINE_BYTES / LINE_BYTES  head entry contents, line-aligned address.
REQ-018 mem_bvalid  in  1  one-cycle write-complete response.
REQ-019 empty, full  out  1 each; count  out  log2(DEPTH)+1  occupied entries.

Function
REQ-020 Entries SHALL form a circular FIFO with head/tail pointers wrapping modulo DEPTH; each entry holds a line address, data, byte mask and valid bit.
REQ-021 cpu_wready SHALL be 1 when count < DEPTH, or when the write merges (REQ-022); a write is taken on cpu_wvalid & cpu_wready.
REQ-022 Merge: if the line address matches a valid, unlocked entry, only the bytes with cpu_wstrb=1 SHALL be overwritten and the mask OR-ed with cpu_wstrb; count unchanged. Merge is accepted even when full.
REQ-023 Allocate: with no unlocked match, the write SHALL go to the tail entry (data, mask=cpu_wstrb, valid=1), tail+1, count+1.
REQ-024 Drain FSM states: IDLE, SEND, WAIT_B. IDLE->SEND when head valid; SEND->WAIT_B on mem_wready; WAIT_B->IDLE on mem_bvalid, invalidating head, head+1, count-1.
REQ-025 mem_wvalid SHALL equal (state==SEND); mem_w* SHALL hold the head entry and stay stable while mem_wvalid=1 and mem_wready=0.
REQ-026 The head entry SHALL be locked in SEND and WAIT_B; a matching write then allocates a new entry instead of merging, so at most one unlocked entry exists per line.
REQ-027 A pop and an allocate in the same cycle SHALL leave count unchanged; cpu_wready is computed from the pre-pop count (no same-cycle pass-through when full).
REQ-028 Read lookup SHALL be combinational, same cycle: cpu_rmask = OR of masks of all valid matches; each byte of cpu_rdata is taken from the youngest matching entry holding it.
REQ-029 Lookup SHALL see pre-write state; a write accepted in cycle N becomes visible to reads in cycle N+1.
REQ-030 empty = (count==0); full = (count==DEPTH).
REQ-031 mem_bvalid outside WAIT_B and mem_wready outside SEND SHALL be ignored.

Reset
REQ-032 On rst=0, immediately and regardless of clk: all valid bits 0, head=tail=0, count=0, FSM=IDLE.
REQ-033 During reset: mem_wvalid=0, cpu_rhit=0, cpu_rmask=0, cpu_rdata=0, empty=1, full=0, cpu_wready=1. Entry data/address storage need not be reset.
REQ-034 Reset asserted mid-transaction (SEND or WAIT_B) SHALL discard the transaction; a subsequent mem_bvalid has no effect.

Verification (DEPTH=4, LINE_BYTES=32)
REQ-035 Write 0x1000, strb=0x0000000F, then 0x1004 strb=0x000000F0 while memory stalls -> count=1, mem_wstrb=0x000000FF.
REQ-036 Four distinct lines with mem_wready=0 -> full=1, cpu_wready=0 for a fifth new line, and cpu_wready=1 for a write to one of the buffered unlocked lines.
REQ-037 Line 0x2000 in WAIT_B, write 0x2000 strb=0x1 -> new entry, count=2; read 0x2000 returns byte0 from the new entry, mask = union of both.
REQ-038 Full buffer, mem_bvalid and a new-line write in the same cycle -> write rejected, count 4->3; next cycle accepted, count=4.
REQ-039 Read 0x3000 with no match -> cpu_rhit=0, cpu_rdata=0, cpu_rmask=0.
REQ-040 rst=0 while in SEND with count=3 -> mem_wvalid=0 and empty=1 without a clock edge; after release, mem_bvalid pulse -> count stays 0.
